// File: rtl/tile_map_scheduler.sv
// Shares the single tile-map BRAM port between VGA tile fetches (always first)
// and round-robin nibble read-modify-write requests from game-logic writers.
module tile_map_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int MAP_W      = 20,
  parameter int MAP_H      = 15,
  parameter int ROW_STRIDE = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_vga_req,
  input  logic [4:0]           i_vga_cell_x,
  input  logic [3:0]           i_vga_cell_y,
  output logic [3:0]           o_vga_tile,
  output logic                 o_vga_tile_valid,
  input  logic [NUM_REQ-1:0]   i_wr_valid,
  input  logic [5*NUM_REQ-1:0] i_wr_x,
  input  logic [4*NUM_REQ-1:0] i_wr_y,
  input  logic [4*NUM_REQ-1:0] i_wr_tile,
  output logic [NUM_REQ-1:0]   o_wr_ready,
  output logic [NUM_REQ-1:0]   o_wr_done,
  output logic                 o_busy,
  output logic [10:0]          o_bram_addr,
  output logic                 o_bram_we,
  output logic [15:0]          o_bram_wdata,
  input  logic [15:0]          i_bram_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WRITE,
    S_DROP
  } state_t;

  function automatic logic [10:0] cell_addr(input logic [4:0] x, input logic [3:0] y);
    return 11'(y) * 11'(ROW_STRIDE) + 11'(x[4:2]);
  endfunction

  // Cell 0 of a word sits in the most significant nibble.
  function automatic logic [3:0] get_nibble(input logic [15:0] w, input logic [1:0] sel);
    logic [3:0] n;
    case (sel)
      2'd0:    n = w[15:12];
      2'd1:    n = w[11:8];
      2'd2:    n = w[7:4];
      default: n = w[3:0];
    endcase
    return n;
  endfunction

  function automatic logic [15:0] put_nibble(input logic [15:0] w, input logic [1:0] sel,
                                             input logic [3:0] t);
    logic [15:0] r;
    r = w;
    case (sel)
      2'd0:    r[15:12] = t;
      2'd1:    r[11:8]  = t;
      2'd2:    r[7:4]   = t;
      default: r[3:0]   = t;
    endcase
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, owner_q;
  logic [4:0]         wx_q;
  logic [3:0]         wy_q, wtile_q;
  logic [15:0]        hold_q, hold_d;
  logic [10:0]        bram_addr_q, bram_addr_d;
  logic               bram_we_q, bram_we_d;
  logic [15:0]        bram_wdata_q, bram_wdata_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               fsm_rd_d, fsm_rd_p1_q, fsm_rd_p2_q;
  logic               vga_vld_p1_q, vga_vld_p2_q;
  logic [1:0]         vga_sel_p1_q, vga_sel_p2_q;
  logic [3:0]         vga_tile_q;
  logic               vga_valid_q;

  logic               grant_vld, take_grant, win_oob;
  logic [IDX_W-1:0]   grant_idx, ptr_next;
  logic [4:0]         win_x;
  logic [3:0]         win_y, win_tile;

  // Round-robin search starting at ptr_q; lowest offset wins.
  always_comb begin
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (i_wr_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  assign win_x    = i_wr_x[int'(grant_idx)*5 +: 5];
  assign win_y    = i_wr_y[int'(grant_idx)*4 +: 4];
  assign win_tile = i_wr_tile[int'(grant_idx)*4 +: 4];
  assign win_oob  = (win_x >= 5'(MAP_W)) || (win_y >= 4'(MAP_H));
  assign ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (!i_vga_req && grant_vld) state_d = win_oob ? S_DROP : S_RD_ISSUE;
      S_RD_ISSUE: if (!i_vga_req) state_d = S_RD_WAIT;
      S_RD_WAIT:  if (fsm_rd_p2_q) state_d = S_WRITE;
      S_WRITE:    if (!i_vga_req) state_d = S_IDLE;
      S_DROP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Port owner for the next cycle: VGA first, otherwise the FSM's pending access.
  always_comb begin
    take_grant   = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_we_d    = 1'b0;
    bram_wdata_d = bram_wdata_q;
    fsm_rd_d     = 1'b0;
    done_d       = '0;
    hold_d       = hold_q;
    if (i_vga_req) begin
      bram_addr_d = cell_addr(i_vga_cell_x, i_vga_cell_y);
    end else begin
      case (state_q)
        S_IDLE: begin
          take_grant = grant_vld;
          if (grant_vld && win_oob) done_d = NUM_REQ'(1) << grant_idx;
        end
        S_RD_ISSUE: begin
          bram_addr_d = cell_addr(wx_q, wy_q);
          fsm_rd_d    = 1'b1;
        end
        S_WRITE: begin
          bram_addr_d  = cell_addr(wx_q, wy_q);
          bram_we_d    = 1'b1;
          bram_wdata_d = hold_q;
          done_d       = NUM_REQ'(1) << owner_q;
        end
        default: ;
      endcase
    end
    if (state_q == S_RD_WAIT && fsm_rd_p2_q) hold_d = put_nibble(i_bram_rdata, wx_q[1:0], wtile_q);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ptr_q        <= '0;
      owner_q      <= '0;
      wx_q         <= '0;
      wy_q         <= '0;
      wtile_q      <= '0;
      hold_q       <= '0;
      bram_addr_q  <= '0;
      bram_we_q    <= 1'b0;
      bram_wdata_q <= '0;
      done_q       <= '0;
      fsm_rd_p1_q  <= 1'b0;
      fsm_rd_p2_q  <= 1'b0;
      vga_vld_p1_q <= 1'b0;
      vga_vld_p2_q <= 1'b0;
      vga_sel_p1_q <= '0;
      vga_sel_p2_q <= '0;
      vga_tile_q   <= '0;
      vga_valid_q  <= 1'b0;
    end else begin
      if (take_grant) begin
        ptr_q   <= ptr_next;
        owner_q <= grant_idx;
        wx_q    <= win_x;
        wy_q    <= win_y;
        wtile_q <= win_tile;
      end
      hold_q       <= hold_d;
      bram_addr_q  <= bram_addr_d;
      bram_we_q    <= bram_we_d;
      bram_wdata_q <= bram_wdata_d;
      done_q       <= done_d;
      // p1: address on the BRAM port; p2: read data returning with its owner tag
      fsm_rd_p1_q  <= fsm_rd_d;
      fsm_rd_p2_q  <= fsm_rd_p1_q;
      vga_vld_p1_q <= i_vga_req;
      vga_vld_p2_q <= vga_vld_p1_q;
      vga_sel_p1_q <= i_vga_cell_x[1:0];
      vga_sel_p2_q <= vga_sel_p1_q;
      if (vga_vld_p2_q) vga_tile_q <= get_nibble(i_bram_rdata, vga_sel_p2_q);
      vga_valid_q  <= vga_vld_p2_q;
    end
  end

  // Ready is gated by reset so a held request cannot show acceptance while in reset.
  assign o_wr_ready       = (take_grant && i_Rst_n) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign o_wr_done        = done_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_bram_addr      = bram_addr_q;
  assign o_bram_we        = bram_we_q;
  assign o_bram_wdata     = bram_wdata_q;
  assign o_vga_tile       = vga_tile_q;
  assign o_vga_tile_valid = vga_valid_q;

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Directed bench for tile_map_scheduler with a registered-read BRAM model.
module tb_tile_map_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           vga_req;
  logic [4:0]     vga_x;
  logic [3:0]     vga_y;
  logic [3:0]     vga_tile;
  logic           vga_valid;
  logic [N-1:0]   wr_valid;
  logic [5*N-1:0] wr_x;
  logic [4*N-1:0] wr_y;
  logic [4*N-1:0] wr_tile;
  logic [N-1:0]   wr_ready;
  logic [N-1:0]   wr_done;
  logic           busy;
  logic [10:0]    addr;
  logic           we;
  logic [15:0]    wdata;
  logic [15:0]    rdata;

  logic [15:0]    mem [0:2047];
  logic           ld_clr, ld_en;
  logic [10:0]    ld_addr;
  logic [15:0]    ld_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] gq[$];
  int         gc[$];
  logic [3:0] exp_g [4];

  tile_map_scheduler #(.NUM_REQ(N), .MAP_W(20), .MAP_H(15), .ROW_STRIDE(16)) dut (
    .i_Clk           (clk),
    .i_Rst_n         (rst_n),
    .i_vga_req       (vga_req),
    .i_vga_cell_x    (vga_x),
    .i_vga_cell_y    (vga_y),
    .o_vga_tile      (vga_tile),
    .o_vga_tile_valid(vga_valid),
    .i_wr_valid      (wr_valid),
    .i_wr_x          (wr_x),
    .i_wr_y          (wr_y),
    .i_wr_tile       (wr_tile),
    .o_wr_ready      (wr_ready),
    .o_wr_done       (wr_done),
    .o_busy          (busy),
    .o_bram_addr     (addr),
    .o_bram_we       (we),
    .o_bram_wdata    (wdata),
    .i_bram_rdata    (rdata)
  );

  // Single-port BRAM, read-first, one cycle read latency
  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 16'h0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    #3;
  endtask

  task automatic set_wr(input int k, input logic [4:0] x, input logic [3:0] y, input logic [3:0] t);
    wr_x[5*k +: 5]    = x;
    wr_y[4*k +: 4]    = y;
    wr_tile[4*k +: 4] = t;
  endtask

  task automatic check_reset(input string p);
    chk({p, "_addr"},  32'(addr),      32'h0);
    chk({p, "_we"},    32'(we),        32'h0);
    chk({p, "_wdata"}, 32'(wdata),     32'h0);
    chk({p, "_tile"},  32'(vga_tile),  32'h0);
    chk({p, "_valid"}, 32'(vga_valid), 32'h0);
    chk({p, "_ready"}, 32'(wr_ready),  32'h0);
    chk({p, "_done"},  32'(wr_done),   32'h0);
    chk({p, "_busy"},  32'(busy),      32'h0);
  endtask

  initial begin
    rst_n = 1'b0; vga_req = 1'b0; vga_x = '0; vga_y = '0;
    wr_valid = '0; wr_x = '0; wr_y = '0; wr_tile = '0;
    ld_clr = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    exp_g = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};

    step(); ld_clr = 1'b0; ld_en = 1'b1; ld_addr = 11'd33;  ld_data = 16'h6606;
    step(); ld_addr = 11'd226; ld_data = 16'h1111;
    step(); ld_addr = 11'd48;  ld_data = 16'hABCD;
    step(); ld_en = 1'b0;
    probe(); check_reset("rst");
    step(); rst_n = 1'b1;

    // VGA reads: (5,2) (7,2) (6,2) back to back, word 0x6606 at 33
    step(); vga_req = 1'b1; vga_x = 5'd5; vga_y = 4'd2;
    probe(); chk("vga_v_d0", 32'(vga_valid), 32'h0);
    step(); vga_x = 5'd7;
    probe(); chk("vga_addr_d1", 32'(addr), 32'd33); chk("vga_v_d1", 32'(vga_valid), 32'h0);
    step(); vga_x = 5'd6;
    probe(); chk("vga_v_d2", 32'(vga_valid), 32'h0);
    step(); vga_req = 1'b0;
    probe(); chk("vga_v_d3", 32'(vga_valid), 32'h1); chk("vga_t_x5", 32'(vga_tile), 32'h6);
    step();
    probe(); chk("vga_v_d4", 32'(vga_valid), 32'h1); chk("vga_t_x7", 32'(vga_tile), 32'h6);
    step();
    probe(); chk("vga_v_d5", 32'(vga_valid), 32'h1); chk("vga_t_x6", 32'(vga_tile), 32'h0);
    step();
    probe(); chk("vga_v_d6", 32'(vga_valid), 32'h0);

    // Writer 1: tile 2 into (9,14), word 0x1111 at 226 -> 0x1211
    step(); set_wr(1, 5'd9, 4'd14, 4'h2); wr_valid = 4'b0010;
    probe(); chk("w1_ready", 32'(wr_ready), 32'h2); chk("w1_busy_g", 32'(busy), 32'h0);
    step(); wr_valid = '0;
    probe(); chk("w1_ready_g1", 32'(wr_ready), 32'h0); chk("w1_busy_g1", 32'(busy), 32'h1);
    step();
    probe(); chk("w1_rdaddr", 32'(addr), 32'd226); chk("w1_we_g2", 32'(we), 32'h0);
    step();
    probe(); chk("w1_we_g3", 32'(we), 32'h0);
    step();
    probe(); chk("w1_we_g4", 32'(we), 32'h0); chk("w1_done_g4", 32'(wr_done), 32'h0);
    step();
    probe(); chk("w1_we_g5", 32'(we), 32'h1); chk("w1_waddr", 32'(addr), 32'd226);
    chk("w1_wdata", 32'(wdata), 32'h1211); chk("w1_done_g5", 32'(wr_done), 32'h2);
    step();
    probe(); chk("w1_we_g6", 32'(we), 32'h0); chk("w1_done_g6", 32'(wr_done), 32'h0);
    chk("w1_busy_g6", 32'(busy), 32'h0); chk("w1_mem", 32'(mem[226]), 32'h1211);

    // Writer 0: out-of-range (20,0) is dropped
    step(); set_wr(0, 5'd20, 4'd0, 4'h7); wr_valid = 4'b0001;
    probe(); chk("drop_ready", 32'(wr_ready), 32'h1); chk("drop_we_g", 32'(we), 32'h0);
    step(); wr_valid = '0;
    probe(); chk("drop_done", 32'(wr_done), 32'h1); chk("drop_busy", 32'(busy), 32'h1);
    chk("drop_we_g1", 32'(we), 32'h0);
    step();
    probe(); chk("drop_done_g2", 32'(wr_done), 32'h0); chk("drop_busy_g2", 32'(busy), 32'h0);
    chk("drop_we_g2", 32'(we), 32'h0);

    // Writer 3: tile 5 into (3,3) while VGA holds the port for 10 cycles
    step(); set_wr(3, 5'd3, 4'd3, 4'h5); wr_valid = 4'b1000;
    probe(); chk("stall_ready", 32'(wr_ready), 32'h8);
    for (int c = 1; c <= 15; c++) begin
      step();
      wr_valid = '0;
      vga_req = (c <= 10); vga_x = 5'd5; vga_y = 4'd2;
      probe();
      chk($sformatf("stall_we_%0d", c), 32'(we), 32'(c == 15));
      chk($sformatf("stall_busy_%0d", c), 32'(busy), 32'(c <= 14));
      chk($sformatf("stall_vld_%0d", c), 32'(vga_valid), 32'(c >= 4 && c <= 13));
      if (c >= 4 && c <= 13) chk($sformatf("stall_tile_%0d", c), 32'(vga_tile), 32'h6);
      if (c == 12) chk("stall_rdaddr", 32'(addr), 32'd48);
      if (c == 15) begin
        chk("stall_waddr", 32'(addr), 32'd48);
        chk("stall_wdata", 32'(wdata), 32'hABC5);
        chk("stall_done", 32'(wr_done), 32'h8);
      end
    end
    step();
    probe(); chk("stall_mem", 32'(mem[48]), 32'hABC5); chk("stall_done_after", 32'(wr_done), 32'h0);

    // Writer 2: reset while stalled in WRITE
    step(); set_wr(2, 5'd1, 4'd0, 4'h9); wr_valid = 4'b0100;
    probe(); chk("rw_ready", 32'(wr_ready), 32'h4);
    step(); wr_valid = '0;
    step();
    step();
    step(); vga_req = 1'b1; vga_x = 5'd5; vga_y = 4'd2;
    probe(); chk("rw_busy_g4", 32'(busy), 32'h1); chk("rw_we_g4", 32'(we), 32'h0);
    step();
    probe(); chk("rw_we_g5", 32'(we), 32'h0);
    step(); rst_n = 1'b0;
    set_wr(0, 5'd1, 4'd1, 4'h4); set_wr(2, 5'd2, 4'd1, 4'h8); set_wr(3, 5'd3, 4'd1, 4'hC);
    wr_valid = 4'b1101;
    probe(); check_reset("midrst");
    chk("midrst_mem0", 32'(mem[0]), 32'h0);

    // After release, writers 0,2,3 held valid: grants 0,2,3,0 every 5 cycles
    step(); rst_n = 1'b1; vga_req = 1'b0;
    for (int c = 0; c < 18; c++) begin
      if (c != 0) step();
      probe();
      if (wr_ready != '0) begin
        gq.push_back(wr_ready);
        gc.push_back(c);
      end
    end
    wr_valid = '0;
    chk("rr_count_ge4", 32'(gq.size() >= 4), 32'h1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_grant_%0d", k), 32'((k < gq.size()) ? gq[k] : 4'hF), 32'(exp_g[k]));
      chk($sformatf("rr_cycle_%0d", k), 32'((k < gc.size()) ? gc[k] : -1), 32'(5 * k));
    end
    chk("rr_mem0", 32'(mem[0]), 32'h0);

    repeat (8) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
